uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
Transmit shift engine of the UART. Accepts a byte on a one-cycle load strobe and serialises it as an async frame: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit. Emits a one-cycle tx_done pulse at frame end. tx_done drives the SET input of the downstream transmit-ready set/reset flag; the same load strobe drives that flag's RESET.

Parameters:
K_W, 20, width of baud_k (bit-period count in clk cycles)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
load  input  1  one-cycle write strobe; starts a frame when engine idle
din  input  8  transmit data; din[7] ignored when eight=0
baud_k  input  K_W  bit period in clk cycles; values 0 and 1 are treated as 2
eight  input  1  1 = 8 data bits, 0 = 7 data bits
pen  input  1  parity enable
ohel  input  1  parity sense: 1 = odd, 0 = even
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse at frame completion; to S of transmit-ready flag

Behaviour:
- Reset (async, active-high) forces tx=1, busy=0, tx_done=0, state=IDLE, bit and baud counters cleared; applies immediately, including mid-frame.
- States: IDLE, SHIFT.
- IDLE: tx=1, busy=0. When load=1 is sampled on an edge:
  - latch din, eight, pen, ohel and the clamped baud_k into internal registers;
  - load the frame shift register;
  - enter SHIFT; tx=0 (start bit) and busy=1 from that same edge.
- Frame length N = 1 + (eight?8:7) + (pen?1:0) + 1, giving 9 to 11 bits.
- Parity: even = XOR of transmitted data bits; odd = its inverse. Only the 7 or 8 transmitted bits are included.
- SHIFT: each bit is held for exactly K clocks (K = latched clamped baud_k). The baud counter counts 0..K-1, then the next bit is presented. The bit counter tracks bits sent.
- End of frame: at edge E0 + N*K, where E0 is the edge that drove the start bit:
  - state returns to IDLE, busy=0, tx=1;
  - tx_done=1 for exactly one cycle.
- Input changes during SHIFT have no effect on the frame in progress: din, baud_k, eight, pen and ohel are all latched at load.
- load while in SHIFT is ignored: no restart, no effect on the frame, no extra tx_done.
- load sampled in the cycle tx_done is high is accepted, since state is IDLE. The minimum idle gap between frames is one clock of stop-level high beyond the stop bit.
- Outputs are registered; there is no combinational path from inputs to tx, busy or tx_done.
- Exactly one tx_done per accepted load. A frame aborted by reset produces no tx_done.

Test Plan:
- Reset, then baud_k=4, eight=1, pen=0, load din=0x55 -> tx bits 0,1,0,1,0,1,0,1,0,1, each 4 clocks; tx_done pulses once 40 clocks after tx falls; busy low from the same edge.
- baud_k=4, eight=1, pen=1, din=0x03: ohel=0 gives parity bit 0, ohel=1 gives parity bit 1; 11-bit frame; tx_done at 44 clocks.
- eight=0, pen=0, din=0xFF, baud_k=3 -> tx 0,1,1,1,1,1,1,1,1 (9 bits, din[7] not sent); tx_done at 27 clocks.
- During a frame, pulse load with din=0xA5 and change baud_k -> waveform identical to the undisturbed frame; single tx_done.
- Assert reset at bit 4 of a frame -> tx=1, busy=0 immediately; no tx_done; a subsequent load of 0x0F transmits correctly.
- baud_k=0 with din=0x00 -> bits held 2 clocks each; load asserted in the tx_done cycle starts the next frame on that edge.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit shift engine of the UART. A one-cycle load strobe, seen while
//   idle, captures a byte and its frame options. The byte is then sent as an
//   async frame: start bit, 7 or 8 data bits LSB first, optional parity and
//   one stop bit. tx_done pulses for one cycle when the frame ends.
//
//   state  | meaning
//   IDLE   | line high, waiting for load
//   SHIFT  | frame in progress, each bit held for K clocks
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   load     in   one-cycle write strobe, accepted only in IDLE
//   din      in   transmit byte (din[7] unused for 7-bit frames)
//   baud_k   in   bit period in clk cycles (0 and 1 are treated as 2)
//   eight    in   1 = 8 data bits, 0 = 7 data bits
//   pen      in   parity enable
//   ohel     in   parity sense, 1 = odd, 0 = even
//   tx       out  serial line, idle high
//   busy     out  frame in progress
//   tx_done  out  one-cycle pulse at frame end
module uart_tx_engine #(
  parameter int K_W = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [7:0]     din,
  input  logic [K_W-1:0] baud_k,
  input  logic           eight,
  input  logic           pen,
  input  logic           ohel,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_tx;
  logic           r_busy;
  logic           r_done;
  // Holds every bit after the start bit, pre-filled with ones above the
  // stop bit so shifting out never exposes a stale value.
  logic [9:0]     r_shift;
  logic [3:0]     r_bit_cnt;
  logic [3:0]     r_last_bit;
  logic [K_W-1:0] r_baud_cnt;
  logic [K_W-1:0] r_k;

  logic [K_W-1:0] w_k_clamped;
  logic [7:0]     w_data_mask;
  logic           w_parity;
  logic [9:0]     w_frame;
  logic [3:0]     w_last_bit;
  logic           w_bit_end;
  logic           w_start;
  logic           w_frame_end;

  assign w_k_clamped = (baud_k < K_W'(2)) ? K_W'(2) : baud_k;
  assign w_bit_end   = (r_baud_cnt == r_k - K_W'(1));
  // Index of the stop bit: start + data + optional parity.
  assign w_last_bit  = (eight ? 4'd9 : 4'd8) + {3'b000, pen};

  always_comb begin
    w_data_mask = eight ? 8'hFF : 8'h7F;
    w_parity    = (^(din & w_data_mask)) ^ ohel;
    w_frame     = '1;
    if (eight) begin
      w_frame[7:0] = din;
      w_frame[8]   = pen ? w_parity : 1'b1;
    end else begin
      w_frame[6:0] = din[6:0];
      w_frame[7]   = pen ? w_parity : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_bit_end && (r_bit_cnt == r_last_bit)) begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '1;
      r_bit_cnt  <= '0;
      r_last_bit <= '0;
      r_baud_cnt <= '0;
      r_k        <= K_W'(2);
    end else begin
      r_done <= w_frame_end;
      if (w_start) begin
        r_tx       <= 1'b0;
        r_busy     <= 1'b1;
        r_shift    <= w_frame;
        r_k        <= w_k_clamped;
        r_last_bit <= w_last_bit;
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (w_frame_end) begin
        r_tx       <= 1'b1;
        r_busy     <= 1'b0;
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_bit_end) begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= r_bit_cnt + 4'd1;
          r_tx       <= r_shift[0];
          r_shift    <= {1'b1, r_shift[9:1]};
        end else begin
          r_baud_cnt <= r_baud_cnt + K_W'(1);
        end
      end
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule
